// File: rtl/gen_big_field_pkg.sv
// Shared definitions for the big-field stream generator.
// Contents: FSM state type and the beat-geometry helpers (ceil-div, final-beat lane count).
package gen_big_field_pkg;

  typedef enum logic [0:0] {
    StIdle,
    StSend
  } state_e;

  // Number of beats needed to carry num elements at den elements per beat.
  function automatic int unsigned ceil_div(input int unsigned num, input int unsigned den);
    if (den == 0) return 0;
    return (num + den - 1) / den;
  endfunction

  // Lanes occupied on the final beat of a frame.
  function automatic int unsigned last_rem(input int unsigned len, input int unsigned lanes);
    return len - (ceil_div(len, lanes) - 1) * lanes;
  endfunction

endpackage

// File: rtl/axi_stream_inf.sv
// AXI4-Stream bundle used by the big-field generator.
// Signals: tdata/tkeep/tvalid/tlast/tuser driven by the master, tready driven by the slave.
interface axi_stream_inf #(
  parameter int unsigned DataWidth = 8,
  parameter int unsigned KeepWidth = 1
);

  logic [DataWidth-1:0] tdata;
  logic [KeepWidth-1:0] tkeep;
  logic                 tvalid;
  logic                 tready;
  logic                 tlast;
  logic                 tuser;

  modport master (output tdata, output tkeep, output tvalid, output tlast, output tuser,
                  input tready);
  modport slave  (input tdata, input tkeep, input tvalid, input tlast, input tuser,
                  output tready);

endinterface

// File: rtl/big_field_beat_mux.sv
// Combinational beat selector: picks the LANES elements of the current beat out of the
// captured frame and builds the matching tkeep.
// Ports:
//   frame - captured field, element 0 in the most significant DSIZE bits
//   beat  - index of the beat being presented
//   tdata - lane k in tdata[DSIZE*(k+1)-1 -: DSIZE]; unused lanes are zero
//   tkeep - all ones except on the final beat, where only the low REM lanes are set
module big_field_beat_mux
  import gen_big_field_pkg::*;
#(
  parameter int unsigned DSIZE     = 8,
  parameter int unsigned FIELD_LEN = 128,
  parameter int unsigned LANES     = 1,
  parameter int unsigned BW        = 1
) (
  input  logic [DSIZE*FIELD_LEN-1:0] frame,
  input  logic [BW-1:0]              beat,
  output logic [DSIZE*LANES-1:0]     tdata,
  output logic [LANES-1:0]           tkeep
);

  localparam int unsigned BEATS = ceil_div(FIELD_LEN, LANES);
  localparam int unsigned REM   = last_rem(FIELD_LEN, LANES);
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);

  always_comb begin
    tdata = '0;
    tkeep = '0;
    for (int unsigned k = 0; k < LANES; k++) begin
      if ((beat != LastBeat) || (k < REM)) begin
        tkeep[k] = 1'b1;
        // Element index = beat*LANES + k, counted down from the MSB end of the frame.
        tdata[DSIZE*k +: DSIZE] =
          frame[DSIZE*(FIELD_LEN - 1 - (32'(beat) * LANES + k)) +: DSIZE];
      end
    end
  end

endmodule

// File: rtl/gen_big_field_stream.sv
// Streams a wide parallel field out as an AXI4-Stream frame, LANES elements per beat.
// Ports:
//   clock     - single clock
//   rst_n     - asynchronous active-low reset; abandons any frame in flight
//   enable    - "ON": one frame per rising edge; "OFF": frames repeat while high
//   value     - field to send, element 0 in the most significant DSIZE bits
//   busy      - a frame is in flight
//   frame_cnt - completed frames, wrapping at 16 bits
//   cm_tb     - AXI-Stream master (tuser marks the first beat, tlast the final one)
module gen_big_field_stream
  import gen_big_field_pkg::*;
#(
  parameter string       MASTER_MODE = "ON",
  parameter int unsigned DSIZE       = 8,
  parameter int unsigned FIELD_LEN   = 128,
  parameter int unsigned LANES       = 1,
  parameter string       FIELD_NAME  = "Big Field"
) (
  input  logic                       clock,
  input  logic                       rst_n,
  input  logic                       enable,
  input  logic [DSIZE*FIELD_LEN-1:0] value,
  output logic                       busy,
  output logic [15:0]                frame_cnt,
  axi_stream_inf.master              cm_tb
);

  localparam int unsigned BEATS = ceil_div(FIELD_LEN, LANES);
  localparam int unsigned BW    = $clog2(BEATS + 1);
  localparam logic [BW-1:0] LastBeat = BW'(BEATS - 1);
  localparam bit OneShot = (MASTER_MODE == "ON");

  if ((FIELD_LEN < 1) || (FIELD_LEN > 4096) || (LANES < 1) || (LANES > 32)) begin : g_param_check
    $fatal(1, "%s: FIELD_LEN=%0d (legal 1..4096), LANES=%0d (legal 1..32)",
           FIELD_NAME, FIELD_LEN, LANES);
  end

  state_e                     state_q, state_d;
  logic [BW-1:0]              beat_q, beat_d;
  logic [DSIZE*FIELD_LEN-1:0] frame_q, frame_d;
  logic [15:0]                frame_cnt_q, frame_cnt_d;
  logic                       prev_en_q;

  logic                       launch;
  logic                       handshake;
  logic                       final_hs;
  logic [DSIZE*LANES-1:0]     mux_data;
  logic [LANES-1:0]           mux_keep;

  // One-shot mode launches on a rising edge only; repeat mode whenever enable is high.
  assign launch    = OneShot ? (enable && !prev_en_q) : enable;
  assign handshake = (state_q == StSend) && cm_tb.tready;
  assign final_hs  = handshake && (beat_q == LastBeat);

  // State register
  always_ff @(posedge clock or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      beat_q      <= '0;
      frame_q     <= '0;
      frame_cnt_q <= '0;
      prev_en_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      frame_q     <= frame_d;
      frame_cnt_q <= frame_cnt_d;
      prev_en_q   <= enable;
    end
  end

  // Next state
  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    frame_d     = frame_q;
    frame_cnt_d = frame_cnt_q;
    unique case (state_q)
      StIdle: begin
        if (launch) begin
          state_d = StSend;
          frame_d = value;
          beat_d  = '0;
        end
      end
      StSend: begin
        if (final_hs) begin
          beat_d      = '0;
          frame_cnt_d = frame_cnt_q + 16'd1;
          // Repeat mode chains the next frame straight off the final handshake.
          if (!OneShot && enable) begin
            frame_d = value;
          end else begin
            state_d = StIdle;
          end
        end else if (handshake) begin
          beat_d = beat_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  big_field_beat_mux #(
    .DSIZE    (DSIZE),
    .FIELD_LEN(FIELD_LEN),
    .LANES    (LANES),
    .BW       (BW)
  ) u_beat_mux (
    .frame(frame_q),
    .beat (beat_q),
    .tdata(mux_data),
    .tkeep(mux_keep)
  );

  // Outputs: derived from registered state only, so they hold while stalled and clear
  // as soon as reset asserts.
  always_comb begin
    busy         = (state_q == StSend);
    cm_tb.tvalid = busy;
    cm_tb.tuser  = busy && (beat_q == '0);
    cm_tb.tlast  = busy && (beat_q == LastBeat);
    cm_tb.tdata  = busy ? mux_data : '0;
    cm_tb.tkeep  = busy ? mux_keep : '0;
  end

  assign frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_gen_big_field_stream.sv
module tb_gen_big_field_stream;

  typedef struct packed {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
    logic        user;
    int unsigned cyc;
  } beat_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic          rst_n;
  logic          en    [4];
  logic          rdy   [4];
  logic [79:0]   val_a;
  logic [79:0]   val_b;
  logic [7:0]    val_c;
  logic [2399:0] val_d;

  logic          busy_w  [4];
  logic [15:0]   cnt_w   [4];
  logic [31:0]   o_data  [4];
  logic [3:0]    o_keep  [4];
  logic          o_valid [4];
  logic          o_last  [4];
  logic          o_user  [4];

  int n_cmp = 0;
  int n_bad = 0;
  int unsigned cyc = 0;

  beat_t       exp_q  [4][$];
  beat_t       obs_q  [4][$];
  logic        m_prev [4];
  logic [15:0] m_cnt  [4];

  axi_stream_inf #(.DataWidth(32), .KeepWidth(4)) if_a ();
  axi_stream_inf #(.DataWidth(32), .KeepWidth(4)) if_b ();
  axi_stream_inf #(.DataWidth(8),  .KeepWidth(1)) if_c ();
  axi_stream_inf #(.DataWidth(8),  .KeepWidth(1)) if_d ();

  gen_big_field_stream #(.MASTER_MODE("ON"), .DSIZE(8), .FIELD_LEN(10), .LANES(4),
    .FIELD_NAME("Field A")) u_dut_a (
    .clock(clock), .rst_n(rst_n), .enable(en[0]), .value(val_a),
    .busy(busy_w[0]), .frame_cnt(cnt_w[0]), .cm_tb(if_a));
  gen_big_field_stream #(.MASTER_MODE("OFF"), .DSIZE(8), .FIELD_LEN(10), .LANES(4),
    .FIELD_NAME("Field B")) u_dut_b (
    .clock(clock), .rst_n(rst_n), .enable(en[1]), .value(val_b),
    .busy(busy_w[1]), .frame_cnt(cnt_w[1]), .cm_tb(if_b));
  gen_big_field_stream #(.MASTER_MODE("ON"), .DSIZE(8), .FIELD_LEN(1), .LANES(1),
    .FIELD_NAME("Field C")) u_dut_c (
    .clock(clock), .rst_n(rst_n), .enable(en[2]), .value(val_c),
    .busy(busy_w[2]), .frame_cnt(cnt_w[2]), .cm_tb(if_c));
  gen_big_field_stream #(.MASTER_MODE("ON"), .DSIZE(8), .FIELD_LEN(300), .LANES(1),
    .FIELD_NAME("Field D")) u_dut_d (
    .clock(clock), .rst_n(rst_n), .enable(en[3]), .value(val_d),
    .busy(busy_w[3]), .frame_cnt(cnt_w[3]), .cm_tb(if_d));

  assign if_a.tready = rdy[0];
  assign if_b.tready = rdy[1];
  assign if_c.tready = rdy[2];
  assign if_d.tready = rdy[3];

  assign o_data[0]  = if_a.tdata;
  assign o_data[1]  = if_b.tdata;
  assign o_data[2]  = 32'(if_c.tdata);
  assign o_data[3]  = 32'(if_d.tdata);
  assign o_keep[0]  = if_a.tkeep;
  assign o_keep[1]  = if_b.tkeep;
  assign o_keep[2]  = 4'(if_c.tkeep);
  assign o_keep[3]  = 4'(if_d.tkeep);
  assign o_valid[0] = if_a.tvalid;
  assign o_valid[1] = if_b.tvalid;
  assign o_valid[2] = if_c.tvalid;
  assign o_valid[3] = if_d.tvalid;
  assign o_last[0]  = if_a.tlast;
  assign o_last[1]  = if_b.tlast;
  assign o_last[2]  = if_c.tlast;
  assign o_last[3]  = if_d.tlast;
  assign o_user[0]  = if_a.tuser;
  assign o_user[1]  = if_b.tuser;
  assign o_user[2]  = if_c.tuser;
  assign o_user[3]  = if_d.tuser;

  function automatic int fl_of(input int id);
    case (id)
      0, 1:    return 10;
      2:       return 1;
      default: return 300;
    endcase
  endfunction

  function automatic int ln_of(input int id);
    return (id < 2) ? 4 : 1;
  endfunction

  function automatic bit one_shot(input int id);
    return id != 1;
  endfunction

  function automatic logic [2399:0] val_of(input int id);
    case (id)
      0:       return 2400'(val_a);
      1:       return 2400'(val_b);
      2:       return 2400'(val_c);
      default: return val_d;
    endcase
  endfunction

  // Expected beats of one frame, straight from the element/lane placement rules.
  function automatic void push_frame(input int id);
    logic [2399:0] v;
    int fl, ln, nb, e;
    beat_t t;
    v  = val_of(id);
    fl = fl_of(id);
    ln = ln_of(id);
    nb = (fl + ln - 1) / ln;
    for (int b = 0; b < nb; b++) begin
      t = '0;
      for (int k = 0; k < ln; k++) begin
        e = b * ln + k;
        if (e < fl) begin
          t.data[8*k +: 8] = v[8*(fl-1-e) +: 8];
          t.keep[k] = 1'b1;
        end
      end
      t.user = (b == 0);
      t.last = (b == nb - 1);
      exp_q[id].push_back(t);
    end
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", name, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_obs(input int id, input int n, input int budget);
    int k = 0;
    while (obs_q[id].size() < n && k < budget) begin
      tick();
      k++;
    end
    check($sformatf("dut%0d reached %0d beats", id, n),
          64'((obs_q[id].size() >= n) ? n : obs_q[id].size()), 64'(n));
  endtask

  // Compare process: every falling edge, check all four DUTs against the model, then
  // advance the model using the inputs that the next rising edge will sample.
  initial begin
    beat_t head;
    bit mv, hs, fin, launch;
    forever begin
      @(negedge clock);
      cyc++;
      for (int id = 0; id < 4; id++) begin
        if (!rst_n) begin
          exp_q[id].delete();
          m_prev[id] = 1'b0;
          m_cnt[id]  = '0;
        end
        mv   = exp_q[id].size() > 0;
        head = mv ? exp_q[id][0] : '0;
        check($sformatf("dut%0d tvalid", id), 64'(o_valid[id]), 64'(mv));
        check($sformatf("dut%0d busy", id), 64'(busy_w[id]), 64'(mv));
        check($sformatf("dut%0d frame_cnt", id), 64'(cnt_w[id]), 64'(m_cnt[id]));
        if (mv || !rst_n) begin
          check($sformatf("dut%0d tdata", id), 64'(o_data[id]), 64'(head.data));
          check($sformatf("dut%0d tkeep", id), 64'(o_keep[id]), 64'(head.keep));
          check($sformatf("dut%0d tlast", id), 64'(o_last[id]), 64'(head.last));
          check($sformatf("dut%0d tuser", id), 64'(o_user[id]), 64'(head.user));
        end
        if (rst_n) begin
          hs  = mv && rdy[id];
          fin = 1'b0;
          if (hs) begin
            obs_q[id].push_back('{data: o_data[id], keep: o_keep[id], last: o_last[id],
                                  user: o_user[id], cyc: cyc});
            void'(exp_q[id].pop_front());
            if (exp_q[id].size() == 0) begin
              fin = 1'b1;
              m_cnt[id]++;
            end
          end
          if (!mv) launch = one_shot(id) ? (en[id] && !m_prev[id]) : en[id];
          else     launch = fin && !one_shot(id) && en[id];
          if (launch) push_frame(id);
          m_prev[id] = en[id];
        end
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 4; i++) begin
      en[i]  = 1'b0;
      rdy[i] = 1'b0;
    end
    val_a = '0;
    val_b = '0;
    val_c = '0;
    for (int i = 0; i < 300; i++) val_d[8*i +: 8] = 8'($urandom);
    repeat (3) tick();
    #1 rst_n = 1'b1;
    tick();
    tick();

    // Single frame, 10 elements over 4 lanes, always ready.
    val_a  = 80'h00010203040506070809;
    rdy[0] = 1'b1;
    en[0]  = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_obs(0, 3, 20);
    tick();
    check("a1 beat count", 64'(obs_q[0].size()), 64'd3);
    check("a1 beat0 data", 64'(obs_q[0][0].data), 64'h03020100);
    check("a1 beat1 data", 64'(obs_q[0][1].data), 64'h07060504);
    check("a1 beat2 data", 64'(obs_q[0][2].data), 64'h00000908);
    check("a1 beat0 keep", 64'(obs_q[0][0].keep), 64'hf);
    check("a1 beat2 keep", 64'(obs_q[0][2].keep), 64'h3);
    check("a1 beat0 user", 64'(obs_q[0][0].user), 64'd1);
    check("a1 beat1 user", 64'(obs_q[0][1].user), 64'd0);
    check("a1 beat1 last", 64'(obs_q[0][1].last), 64'd0);
    check("a1 beat2 last", 64'(obs_q[0][2].last), 64'd1);
    check("a1 frame_cnt", 64'(cnt_w[0]), 64'd1);

    // Back-pressure for 5 cycles on beat 1.
    obs_q[0].delete();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_obs(0, 1, 20);
    rdy[0] = 1'b0;
    repeat (5) tick();
    rdy[0] = 1'b1;
    wait_obs(0, 3, 20);
    tick();
    check("a2 beat count", 64'(obs_q[0].size()), 64'd3);
    check("a2 beat1 data", 64'(obs_q[0][1].data), 64'h07060504);
    check("a2 beat1 stall gap", 64'(obs_q[0][1].cyc - obs_q[0][0].cyc), 64'd6);
    check("a2 frame_cnt", 64'(cnt_w[0]), 64'd2);

    // Second rising edge while sending is dropped.
    obs_q[0].delete();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    tick();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_obs(0, 3, 20);
    repeat (10) tick();
    check("a3 one frame only", 64'(obs_q[0].size()), 64'd3);
    check("a3 frame_cnt", 64'(cnt_w[0]), 64'd3);

    // Asynchronous reset while beat 1 is stalled.
    obs_q[0].delete();
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_obs(0, 1, 20);
    rdy[0] = 1'b0;
    #1;
    check("rst pre tvalid", 64'(o_valid[0]), 64'd1);
    rst_n = 1'b0;
    #1;
    check("rst async tvalid", 64'(o_valid[0]), 64'd0);
    check("rst async busy", 64'(busy_w[0]), 64'd0);
    check("rst async tdata", 64'(o_data[0]), 64'd0);
    check("rst async frame_cnt", 64'(cnt_w[0]), 64'd0);
    tick();
    tick();
    #1 rst_n = 1'b1;
    rdy[0] = 1'b1;
    repeat (10) tick();
    check("rst no beat after release", 64'(obs_q[0].size()), 64'd1);
    en[0] = 1'b1;
    tick();
    en[0] = 1'b0;
    wait_obs(0, 4, 20);
    tick();
    check("rst relaunch beat0", 64'(obs_q[0][1].data), 64'h03020100);
    check("rst relaunch frame_cnt", 64'(cnt_w[0]), 64'd1);

    // Repeat mode: three back-to-back frames, value changed during frame 1.
    val_b  = 80'h00010203040506070809;
    rdy[1] = 1'b1;
    en[1]  = 1'b1;
    tick();
    wait_obs(1, 1, 20);
    val_b = 80'h10111213141516171819;
    wait_obs(1, 7, 20);
    en[1] = 1'b0;
    wait_obs(1, 9, 20);
    repeat (5) tick();
    check("b beat count", 64'(obs_q[1].size()), 64'd9);
    check("b contiguous", 64'(obs_q[1][8].cyc - obs_q[1][0].cyc), 64'd8);
    check("b frame1 beat0", 64'(obs_q[1][0].data), 64'h03020100);
    check("b frame2 beat0", 64'(obs_q[1][3].data), 64'h13121110);
    check("b frame3 beat2", 64'(obs_q[1][8].data), 64'h00001918);
    check("b frame2 user", 64'(obs_q[1][3].user), 64'd1);
    check("b frame_cnt", 64'(cnt_w[1]), 64'd3);

    // Single-element frame.
    val_c  = 8'ha5;
    rdy[2] = 1'b1;
    en[2]  = 1'b1;
    tick();
    en[2] = 1'b0;
    wait_obs(2, 1, 10);
    repeat (5) tick();
    check("c beat count", 64'(obs_q[2].size()), 64'd1);
    check("c data", 64'(obs_q[2][0].data), 64'ha5);
    check("c keep", 64'(obs_q[2][0].keep), 64'd1);
    check("c user", 64'(obs_q[2][0].user), 64'd1);
    check("c last", 64'(obs_q[2][0].last), 64'd1);
    check("c frame_cnt", 64'(cnt_w[2]), 64'd1);

    // 300-element frame with random back-pressure.
    en[3] = 1'b1;
    tick();
    en[3] = 1'b0;
    for (int i = 0; i < 3000 && obs_q[3].size() < 300; i++) begin
      rdy[3] = ($urandom_range(0, 1) == 1);
      tick();
    end
    rdy[3] = 1'b1;
    repeat (3) tick();
    check("d beat count", 64'(obs_q[3].size()), 64'd300);
    if (obs_q[3].size() == 300) begin
      check("d first data", 64'(obs_q[3][0].data), 64'(val_d[2399 -: 8]));
      check("d final data", 64'(obs_q[3][299].data), 64'(val_d[7:0]));
      check("d final last", 64'(obs_q[3][299].last), 64'd1);
    end
    check("d frame_cnt", 64'(cnt_w[3]), 64'd1);

    // Random traffic on all four, checked by the model every cycle.
    for (int i = 0; i < 2000; i++) begin
      for (int id = 0; id < 4; id++) begin
        rdy[id] = ($urandom_range(0, 3) != 0);
        if ($urandom_range(0, 5) == 0) en[id] = ~en[id];
      end
      if ($urandom_range(0, 7) == 0) val_a = {16'($urandom), $urandom, $urandom};
      if ($urandom_range(0, 7) == 0) val_b = {16'($urandom), $urandom, $urandom};
      if ($urandom_range(0, 3) == 0) val_c = 8'($urandom);
      if ($urandom_range(0, 63) == 0) val_d[8*$urandom_range(0, 299) +: 8] = 8'($urandom);
      tick();
    end
    for (int id = 0; id < 4; id++) begin
      en[id]  = 1'b0;
      rdy[id] = 1'b1;
    end
    repeat (400) tick();
    for (int id = 0; id < 4; id++) begin
      check($sformatf("dut%0d drained", id), 64'(o_valid[id]), 64'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
